// File: rtl/ysyx_22041461_pipe_buf.sv
// Elastic DEPTH-entry inter-stage buffer (FIFO) with flush, stall hold and occupancy count.
// Latency: one cycle from push to out_valid; no pass-through when empty.
// Backpressure: in_ready depends only on registered occupancy and flush, never on out_ready.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   flush           synchronous discard of all entries (highest priority)
//   stall           hold the head: suppresses out_valid and pops, pushes continue
//   in_valid/in_ready/in_data     upstream handshake and payload
//   out_valid/out_ready/out_data  downstream handshake and head payload
//   count           registered occupancy, 0..DEPTH
module ysyx_22041461_pipe_buf #(
    parameter  int DW    = 64,
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          stall,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [CW-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wp_q;
    logic [AW-1:0] rp_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          push;
    logic          pop;

    // A full buffer refuses input even if the head drains this cycle; this
    // keeps in_ready off the downstream ready path at the cost of one bubble.
    assign in_ready  = (cnt_q != CW'(DEPTH)) && !flush;
    assign out_valid = (cnt_q != '0) && !stall && !flush;
    assign out_data  = mem_q[rp_q];
    assign count     = cnt_q;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_comb begin
        cnt_d = cnt_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush) begin
            // Pointers rewind; storage is left as-is since it is unreachable.
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) begin
                mem_q[wp_q] <= in_data;
                wp_q        <= wp_q + AW'(1);
            end
            if (pop) begin
                rp_q <= rp_q + AW'(1);
            end
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_ysyx_22041461_pipe_buf.sv
// Self-checking bench for ysyx_22041461_pipe_buf: directed scenarios plus random traffic,
// checked by a queue-based reference model in a separate monitor process.
// Inputs change 1 time unit after the rising edge; the monitor samples on the falling edge.
module tb_ysyx_22041461_pipe_buf;

    localparam int DW    = 64;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          stall;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] count;

    int total = 0;
    int bad   = 0;

    // Reference model: payloads accepted and not yet consumed, in order.
    logic [DW-1:0] exp_q [$];

    always #5 clk = ~clk;

    ysyx_22041461_pipe_buf #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .stall     (stall),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor / scoreboard: predicts handshake outputs from the model queue,
    // compares the head on every predicted transfer, then applies the cycle.
    always @(negedge clk) begin : monitor
        bit m_rdy;
        bit m_vld;
        if (rst) begin
            exp_q.delete();
            check("rst_count", count, 0);
            check("rst_out_valid", out_valid, 0);
        end else begin
            m_rdy = (exp_q.size() != DEPTH) && !flush;
            m_vld = (exp_q.size() != 0) && !stall && !flush;
            check("in_ready", in_ready, m_rdy);
            check("out_valid", out_valid, m_vld);
            check("count", count, exp_q.size());
            if (m_vld && out_ready) begin
                check("out_data", out_data, exp_q[0]);
                void'(exp_q.pop_front());
            end
            if (flush) exp_q.delete();
            else if (in_valid && m_rdy) exp_q.push_back(in_data);
        end
    end

    task automatic set_in(input bit v, input logic [DW-1:0] d, input bit ordy,
                          input bit st, input bit fl);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        stall     = st;
        flush     = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit ordy);
        set_in(0, '0, ordy, 0, 0);
        repeat (n) step();
    endtask

    initial begin
        logic [DW-1:0] val;
        bit acc;
        int guard;

        rst = 1'b1;
        set_in(0, '0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Asynchronous reset with two entries held.
        set_in(1, 64'h11, 0, 0, 0); step();
        set_in(1, 64'h22, 0, 0, 0); step();
        set_in(0, '0, 0, 0, 0);
        check("pre_rst_count", count, 2);
        #2 rst = 1'b1;
        #1;
        check("async_rst_count", count, 0);
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_out_data", out_data, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        set_in(1, 64'hA5, 1, 0, 0); step();
        set_in(0, '0, 1, 0, 0);
        #2;
        check("a5_out_valid", out_valid, 1);
        check("a5_out_data", out_data, 64'hA5);
        step();
        idle(2, 1);

        // Streaming at one transfer per cycle.
        for (int i = 0; i < 8; i++) begin
            set_in(1, 64'h1000 + 64'(i), 1, 0, 0);
            #2;
            check("stream_count_le1", count <= 1, 1);
            @(posedge clk); #1;
        end
        idle(3, 1);

        // Fill to full, then drain while in_valid stays high.
        val = 1;
        for (int i = 0; i < 6; i++) begin
            set_in(val <= 6, val, 0, 0, 0);
            #2 acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) val++;
        end
        check("full_count", count, 4);
        check("full_in_ready", in_ready, 0);
        check("full_next_val", val, 5);
        set_in(1, val, 1, 0, 0);
        #2 acc = in_valid && in_ready;
        check("full_pop_no_push", acc, 0);
        @(posedge clk); #1;
        check("after_full_pop_count", count, 3);
        guard = 0;
        while (val <= 6 && guard < 20) begin
            set_in(1, val, 1, 0, 0);
            #2 acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) val++;
            guard++;
        end
        check("fill_all_accepted", val, 7);
        idle(6, 1);

        // Simultaneous push and pop at one entry.
        set_in(1, 64'h31, 0, 0, 0); step();
        set_in(1, 64'h32, 1, 0, 0); step();
        check("pushpop_count", count, 1);
        idle(2, 1);

        // Stall holds the head while pushes continue.
        set_in(1, 64'h55, 0, 0, 0); step();
        for (int i = 0; i < 3; i++) begin
            set_in(i == 0, 64'h66, 1, 1, 0);
            #2 check("stall_out_valid", out_valid, 0);
            @(posedge clk); #1;
        end
        check("stall_count", count, 2);
        idle(3, 1);

        // Flush beats in_valid and out_ready.
        set_in(1, 64'h81, 0, 0, 0); step();
        set_in(1, 64'h82, 0, 0, 0); step();
        set_in(1, 64'h99, 1, 0, 1);
        #2;
        check("flush_in_ready", in_ready, 0);
        check("flush_out_valid", out_valid, 0);
        @(posedge clk); #1;
        set_in(0, '0, 1, 0, 0);
        #2 check("post_flush_count", count, 0);
        @(posedge clk); #1;
        set_in(1, 64'h77, 1, 0, 0); step();
        set_in(0, '0, 1, 0, 0);
        #2;
        check("post_flush_out_valid", out_valid, 1);
        check("post_flush_out_data", out_data, 64'h77);
        @(posedge clk); #1;
        idle(2, 1);

        // Random traffic, with occasional flush, stall and asynchronous reset.
        for (int i = 0; i < 2000; i++) begin
            set_in($urandom_range(0, 3) != 0, {$urandom, $urandom},
                   $urandom_range(0, 2) != 0, $urandom_range(0, 9) == 0,
                   $urandom_range(0, 29) == 0);
            if ($urandom_range(0, 199) == 0) begin
                #2 rst = 1'b1;
                @(posedge clk);
                #1 rst = 1'b0;
            end else begin
                step();
            end
        end

        // Drain with a bounded wait.
        set_in(0, '0, 1, 0, 0);
        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            step();
            guard++;
        end
        check("drain_done", exp_q.size(), 0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
